// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register front end:
// opcodes, operands, addresses and the read-sweep states.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;

  typedef logic [4:0] address_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_RUN  = 2'd1,
    RD_DONE = 2'd2
  } rd_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; a tie goes to the
// requester that did not win the last handshake.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic valid0,
  input  logic valid1,
  input  logic enable,
  output logic ready0,
  output logic ready1
);

  logic last_grant;
  logic pick0;
  logic pick1;

  // Pick one requester; ready only follows its own valid.
  always_comb begin
    pick1  = valid1 & (~valid0 | ~last_grant);
    pick0  = valid0 & ~pick1;
    ready0 = pick0 & enable;
    ready1 = pick1 & enable;
  end

  // Remember the winner of each completed handshake.
  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= 1'b1;
    else if (ready0 | ready1)
      last_grant <= ready1;
  end

endmodule

// File: rtl/instr_reg_arbiter.sv
// Write-port arbiter, pointer/occupancy tracker and
// read sweeper in front of the instruction register.
module instr_reg_arbiter
  import instr_register_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter bit WRAP  = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  opcode_t                req0_opcode,
  input  operand_t               req0_operand_a,
  input  operand_t               req0_operand_b,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  opcode_t                req1_opcode,
  input  operand_t               req1_operand_a,
  input  operand_t               req1_operand_b,
  output logic                   load_en,
  output opcode_t                opcode,
  output operand_t               operand_a,
  output operand_t               operand_b,
  output address_t               write_pointer,
  output address_t               read_pointer,
  input  logic                   rd_start,
  output logic                   rd_valid,
  output logic                   rd_busy,
  output logic                   rd_done,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          accept;
  logic [CW:0]   occ;
  logic          hs0;
  logic          hs1;
  rd_state_t     rd_state;
  logic [CW-1:0] rd_len;
  logic [CW-1:0] rd_idx;

  assign full = (count == CW'(DEPTH));

  // The write in flight already owns a slot, so it
  // counts against the room left before full.
  assign occ    = {1'b0, count} + {{CW{1'b0}}, load_en};
  assign accept = WRAP || (occ < (CW+1)'(DEPTH));

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .enable (accept),
    .ready0 (req0_ready),
    .ready1 (req1_ready)
  );

  assign hs0 = req0_valid & req0_ready;
  assign hs1 = req1_valid & req1_ready;

  // Register the granted instruction; strobe it next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_en   <= 1'b0;
      opcode    <= ZERO;
      operand_a <= '0;
      operand_b <= '0;
    end else begin
      load_en <= hs0 | hs1;
      if (hs1) begin
        opcode    <= req1_opcode;
        operand_a <= req1_operand_a;
        operand_b <= req1_operand_b;
      end else if (hs0) begin
        opcode    <= req0_opcode;
        operand_a <= req0_operand_a;
        operand_b <= req0_operand_b;
      end
    end
  end

  // Advance the write address and occupancy per store.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_pointer <= '0;
      count         <= '0;
    end else if (load_en) begin
      write_pointer <= write_pointer + 1'b1;
      if (!full)
        count <= count + 1'b1;
    end
  end

  // Read sweep over a snapshot of the stored entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state     <= RD_IDLE;
      rd_len       <= '0;
      rd_idx       <= '0;
      read_pointer <= '0;
    end else begin
      unique case (rd_state)
        RD_IDLE: begin
          if (rd_start) begin
            if (count == '0) begin
              rd_state <= RD_DONE;
            end else begin
              rd_len       <= count;
              rd_idx       <= '0;
              read_pointer <= (WRAP && full) ? write_pointer : '0;
              rd_state     <= RD_RUN;
            end
          end
        end
        RD_RUN: begin
          if (rd_idx == rd_len - 1'b1) begin
            rd_state <= RD_DONE;
          end else begin
            rd_idx       <= rd_idx + 1'b1;
            read_pointer <= read_pointer + 1'b1;
          end
        end
        RD_DONE: rd_state <= RD_IDLE;
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  assign rd_valid = (rd_state == RD_RUN);
  assign rd_busy  = (rd_state == RD_RUN);
  assign rd_done  = (rd_state == RD_DONE);

endmodule

// File: tb/tb_instr_reg_arbiter.sv
// Directed bench for instr_reg_arbiter; one instance
// per WRAP setting, sharing the same stimulus.
module tb_instr_reg_arbiter;
  import instr_register_pkg::*;

  logic     clk = 1'b0;
  logic     reset;
  logic     req0_valid, req1_valid, rd_start;
  opcode_t  req0_opcode, req1_opcode;
  operand_t req0_operand_a, req0_operand_b;
  operand_t req1_operand_a, req1_operand_b;

  logic     r0_w0, r1_w0, le_w0, rv_w0, rb_w0, rdn_w0, fl_w0;
  opcode_t  op_w0;
  operand_t a_w0, b_w0;
  address_t wp_w0, rp_w0;
  logic [5:0] cnt_w0;

  logic     r0_w1, r1_w1, le_w1, rv_w1, rb_w1, rdn_w1, fl_w1;
  opcode_t  op_w1;
  operand_t a_w1, b_w1;
  address_t wp_w1, rp_w1;
  logic [5:0] cnt_w1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_reg_arbiter #(.DEPTH(32), .WRAP(1'b0)) u0 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(r0_w0),
    .req0_opcode(req0_opcode),
    .req0_operand_a(req0_operand_a),
    .req0_operand_b(req0_operand_b),
    .req1_valid(req1_valid), .req1_ready(r1_w0),
    .req1_opcode(req1_opcode),
    .req1_operand_a(req1_operand_a),
    .req1_operand_b(req1_operand_b),
    .load_en(le_w0), .opcode(op_w0),
    .operand_a(a_w0), .operand_b(b_w0),
    .write_pointer(wp_w0), .read_pointer(rp_w0),
    .rd_start(rd_start), .rd_valid(rv_w0),
    .rd_busy(rb_w0), .rd_done(rdn_w0),
    .count(cnt_w0), .full(fl_w0)
  );

  instr_reg_arbiter #(.DEPTH(32), .WRAP(1'b1)) u1 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(r0_w1),
    .req0_opcode(req0_opcode),
    .req0_operand_a(req0_operand_a),
    .req0_operand_b(req0_operand_b),
    .req1_valid(req1_valid), .req1_ready(r1_w1),
    .req1_opcode(req1_opcode),
    .req1_operand_a(req1_operand_a),
    .req1_operand_b(req1_operand_b),
    .load_en(le_w1), .opcode(op_w1),
    .operand_a(a_w1), .operand_b(b_w1),
    .write_pointer(wp_w1), .read_pointer(rp_w1),
    .rd_start(rd_start), .rd_valid(rv_w1),
    .rd_busy(rb_w1), .rd_done(rdn_w1),
    .count(cnt_w1), .full(fl_w1)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset          = 1'b1;
    req0_valid     = 1'b0;
    req1_valid     = 1'b0;
    rd_start       = 1'b0;
    req0_opcode    = ZERO;
    req1_opcode    = ZERO;
    req0_operand_a = 0;
    req0_operand_b = 0;
    req1_operand_a = 0;
    req1_operand_b = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic fill_req0(input int n);
    req0_valid = 1'b1;
    for (int i = 0; i < n; i++) tick();
    req0_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int acc;
    int dn;
    opcode_t  ops [3];
    operand_t oa  [3];
    operand_t ob  [3];
    ops[0] = ADD;  oa[0] = 5; ob[0] = 3;
    ops[1] = SUB;  oa[1] = 9; ob[1] = 2;
    ops[2] = MULT; oa[2] = 4; ob[2] = 4;

    // reset state
    do_reset();
    #1;
    check("rst_load_en", le_w0, 0);
    check("rst_wp", wp_w0, 0);
    check("rst_rp", rp_w0, 0);
    check("rst_count", cnt_w0, 0);
    check("rst_full", fl_w0, 0);
    check("rst_busy", rb_w0, 0);
    check("rst_done", rdn_w0, 0);
    check("rst_ready0", r0_w0, 0);

    // req0 only, three instructions
    for (int k = 0; k < 5; k++) begin
      req0_valid = (k < 3);
      if (k < 3) begin
        req0_opcode    = ops[k];
        req0_operand_a = oa[k];
        req0_operand_b = ob[k];
      end
      #1;
      check("t1_ready0", r0_w0, (k < 3));
      check("t1_ready1", r1_w0, 0);
      check("t1_load_en", le_w0, (k >= 1 && k <= 3));
      if (k >= 1 && k <= 3) begin
        check("t1_opcode", op_w0, ops[k-1]);
        check("t1_opa", a_w0, oa[k-1]);
        check("t1_opb", b_w0, ob[k-1]);
        check("t1_wp", wp_w0, k - 1);
      end
      tick();
    end
    check("t1_count", cnt_w0, 3);
    check("t1_wp_end", wp_w0, 3);

    // both valid: alternate 0,1,0,1
    do_reset();
    req0_opcode = ADD; req0_operand_a = 10; req0_operand_b = 1;
    req1_opcode = SUB; req1_operand_a = 20; req1_operand_b = 2;
    for (int k = 0; k < 5; k++) begin
      req0_valid = (k < 4);
      req1_valid = (k < 4);
      #1;
      check("t2_ready0", r0_w0, (k < 4) && (k % 2 == 0));
      check("t2_ready1", r1_w0, (k < 4) && (k % 2 == 1));
      check("t2_load_en", le_w0, (k >= 1));
      if (k >= 1) begin
        check("t2_opa", a_w0, ((k - 1) % 2 == 0) ? 10 : 20);
        check("t2_wp", wp_w0, k - 1);
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // WRAP=0 fill to full with both valid held
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (r0_w0 | r1_w0) acc++;
      tick();
    end
    check("t3_accepted", acc, 32);
    check("t3_count", cnt_w0, 32);
    check("t3_full", fl_w0, 1);
    check("t3_ready0", r0_w0, 0);
    check("t3_ready1", r1_w0, 0);
    for (int k = 0; k < 5; k++) begin
      check("t3_no_load", le_w0, 0);
      tick();
    end
    check("t3_wp", wp_w0, 0);

    // WRAP=1: 34 writes, then oldest-first sweep
    do_reset();
    fill_req0(34);
    check("t4_wp", wp_w1, 2);
    check("t4_count", cnt_w1, 32);
    check("t4_full", fl_w1, 1);
    check("t4_ready0_wrap", r0_w1, 0);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check("t4_rd_valid", rv_w1, 1);
      check("t4_rp", rp_w1, (2 + i) % 32);
      tick();
    end
    check("t4_rd_done", rdn_w1, 1);
    check("t4_busy_done", rb_w1, 0);
    check("t4_valid_done", rv_w1, 0);
    tick();
    check("t4_rd_done_once", rdn_w1, 0);

    // count 5 sweep, second start ignored
    do_reset();
    fill_req0(5);
    check("t5_count", cnt_w0, 5);
    rd_start = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      rd_start = (i == 2);
      #1;
      check("t5_rd_valid", rv_w0, 1);
      check("t5_busy", rb_w0, 1);
      check("t5_rp", rp_w0, i);
      tick();
    end
    rd_start = 1'b0;
    check("t5_rd_done", rdn_w0, 1);
    check("t5_rd_valid_end", rv_w0, 0);
    tick();
    dn = 0;
    for (int k = 0; k < 3; k++) begin
      dn += int'(rdn_w0) + int'(rv_w0);
      tick();
    end
    check("t5_quiet", dn, 0);
    check("t5_rp_hold", rp_w0, 4);

    // empty sweep
    do_reset();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("t6_rd_done", rdn_w0, 1);
    check("t6_rd_valid", rv_w0, 0);
    tick();
    check("t6_done_once", rdn_w0, 0);
    check("t6_busy", rb_w0, 0);

    // reset mid-sweep
    do_reset();
    fill_req0(5);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    check("t7_busy_mid", rb_w0, 1);
    reset = 1'b1;
    tick();
    check("t7_busy", rb_w0, 0);
    check("t7_count", cnt_w0, 0);
    check("t7_done", rdn_w0, 0);
    reset = 1'b0;
    tick();
    check("t7_no_done", rdn_w0, 0);
    check("t7_no_valid", rv_w0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
